// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and
// bit positions of the packed response flags.
package apb_pkg;

    localparam int APB_ADDRW = 32;
    localparam int APB_DATAW = 32;

    localparam int RSP_ERR_BIT     = 0;
    localparam int RSP_TIMEOUT_BIT = 1;
    localparam int RSP_FLAGS_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// APB requester: one valid/ready command becomes one SETUP+ACCESS transfer,
// with PREADY wait states, optional timeout and a held valid/ready response.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDRW   = APB_ADDRW,
    parameter int DATAW   = APB_DATAW,
    parameter int TIMEOUT = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [ADDRW-1:0] cmd_addr,
    input  logic [DATAW-1:0] cmd_wdata,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DATAW-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             rsp_timeout,

    output logic [ADDRW-1:0] PADDR,
    output logic             PSEL,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [DATAW-1:0] PWDATA,
    input  logic             PREADY,
    input  logic [DATAW-1:0] PRDATA,
    input  logic             PSLVERR
);

    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            TO_EN    = (TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e               state, state_d;
    logic [CW-1:0]            cnt;
    logic [RSP_FLAGS_W-1:0]   flags;
    logic                     accept, done, abort;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= ST_IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                // Completion on the last counted cycle takes priority over abort.
                if (PREADY) begin
                    done    = 1'b1;
                    state_d = ST_RESP;
                end else if (TO_EN && cnt == CNT_LAST) begin
                    abort   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state == ST_IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
        end else begin
            if (accept) begin
                PADDR   <= cmd_addr;
                PWRITE  <= cmd_write;
                if (cmd_write) PWDATA <= cmd_wdata;
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
            end
            if (state == ST_SETUP) PENABLE <= 1'b1;
            if (done || abort) begin
                PSEL    <= 1'b0;
                PENABLE <= 1'b0;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt <= '0;
        end else if (state == ST_SETUP) begin
            cnt <= '0;
        end else if (state == ST_ACCESS && !PREADY && TO_EN) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            flags     <= '0;
        end else begin
            if (done) begin
                rsp_rdata              <= PWRITE ? '0 : PRDATA;
                flags[RSP_ERR_BIT]     <= PSLVERR;
                flags[RSP_TIMEOUT_BIT] <= 1'b0;
                rsp_valid              <= 1'b1;
            end else if (abort) begin
                rsp_rdata              <= '0;
                flags[RSP_ERR_BIT]     <= 1'b1;
                flags[RSP_TIMEOUT_BIT] <= 1'b1;
                rsp_valid              <= 1'b1;
            end else if (state == ST_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_err     = flags[RSP_ERR_BIT];
    assign rsp_timeout = flags[RSP_TIMEOUT_BIT];

endmodule
